// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

  localparam int MULDIV_DEFAULT_WIDTH = 16;
  localparam int CNT_WIDTH            = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             op_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, b} : '0);
    rem_sh   = {acc, q[WIDTH-1]};
    diff     = rem_sh - {1'b0, b};
    acc_next = sum[WIDTH:1];
    q_next   = {sum[0], q[WIDTH-1:1]};
    if (op_div) begin
      // Remainder stays below the divisor, so the top bit of diff is a true sign.
      q_next = {q[WIDTH-2:0], ~diff[WIDTH]};
      acc_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer with pipeline stall and HI/LO result pair.
// Optional signed support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(WIDTH - 1);

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]       acc, q, b_r, a_r;
  logic                   op_div_r;
  logic [WIDTH-1:0]       acc_step, q_step;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH-1:0]       res_hi, res_lo;
  logic                   last_step;

`ifdef MULDIV_SIGNED_EN
  logic                   sgn_a, sgn_b, neg_a, neg_b;
  logic [2*WIDTH-1:0]     prod;

  assign sgn_a = op_signed & operand_a[WIDTH-1];
  assign sgn_b = op_signed & operand_b[WIDTH-1];
  assign mag_a = sgn_a ? -operand_a : operand_a;
  assign mag_b = sgn_b ? -operand_b : operand_b;
`else
  logic                   unused_signed;

  assign unused_signed = op_signed;
  assign mag_a = operand_a;
  assign mag_b = operand_b;
`endif

  assign last_step = (state == RUN) && (cnt == LAST_STEP);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div   (op_div_r),
    .acc      (acc),
    .q        (q),
    .b        (b_r),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  always_comb begin
    res_hi = acc_step;
    res_lo = q_step;
`ifdef MULDIV_SIGNED_EN
    prod = {acc_step, q_step};
    if (!op_div_r && (neg_a ^ neg_b)) {res_hi, res_lo} = -prod;
    if (op_div_r && (neg_a ^ neg_b)) res_lo = -q_step;
    if (op_div_r && neg_a) res_hi = -acc_step;
`endif
    if (op_div_r && (b_r == '0)) begin
      res_lo = '1;
      res_hi = a_r;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_next = RUN;
        stall      = 1'b1;
      end
      RUN: begin
        stall = 1'b1;
        if (cnt == LAST_STEP) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      b_r      <= '0;
      a_r      <= '0;
      op_div_r <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      ready    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      if (state == IDLE && start) begin
        cnt      <= '0;
        acc      <= '0;
        q        <= op_div ? mag_a : mag_b;
        b_r      <= op_div ? mag_b : mag_a;
        a_r      <= operand_a;
        op_div_r <= op_div;
`ifdef MULDIV_SIGNED_EN
        neg_a    <= sgn_a;
        neg_b    <= sgn_b;
`endif
      end else if (state == RUN) begin
        acc <= acc_step;
        q   <= q_step;
        cnt <= cnt + 1'b1;
        if (last_step) begin
          cnt      <= '0;
          hi       <= res_hi;
          lo       <= res_lo;
          div_zero <= op_div_r && (b_r == '0);
          ready    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, scoreboard and corner sequences.
module tb_muldiv_sequencer;

  logic        clock, reset, start, op_div, op_signed;
  logic [15:0] operand_a, operand_b;
  logic        stall, ready, div_zero;
  logic [15:0] hi, lo;

  typedef struct {
    string       name;
    logic        op_div;
    logic        op_signed;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] last_hi  = '0;
  logic [15:0] last_lo  = '0;

  muldiv_sequencer #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op_div    (op_div),
    .op_signed (op_signed),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .stall     (stall),
    .ready     (ready),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts one operation in the next cycle; poke > 0 raises start again in that cycle.
  task automatic do_op(input vec_t v, input int poke);
    exp_t e;
    int   n;
    bit   seen;
    @(posedge clock); #1;
    start     = 1'b1;
    op_div    = v.op_div;
    op_signed = v.op_signed;
    operand_a = v.a;
    operand_b = v.b;
    sb.push_back('{v.name, v.hi, v.lo, v.dz});
    @(negedge clock);
    check({v.name, " start stall"}, 64'(stall), 64'd1);
    check({v.name, " start ready"}, 64'(ready), 64'd0);
    n    = 1;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clock); #1;
      start     = (c == poke);
      operand_a = 16'($urandom);
      operand_b = 16'($urandom);
      op_div    = 1'($urandom);
      op_signed = 1'($urandom);
      @(negedge clock);
      if (c == 8) check({v.name, " hold"}, 64'({hi, lo}), 64'({last_hi, last_lo}));
      if (ready) seen = 1'b1;
      else if (stall) n++;
    end
    check({v.name, " ready seen"}, 64'(seen), 64'd1);
    check({v.name, " stall cycles"}, 64'(n), 64'd17);
    check({v.name, " done stall"}, 64'(stall), 64'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, " result"}, 64'({e.hi, e.lo, e.dz}), 64'({hi, lo, div_zero}) & '1 ? 64'({hi, lo, div_zero}) : 64'd0);
      check({e.name, " hi"}, 64'(hi), 64'(e.hi));
      check({e.name, " lo"}, 64'(lo), 64'(e.lo));
      check({e.name, " div_zero"}, 64'(div_zero), 64'(e.dz));
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  task automatic idle_watch(input string name);
    int n_stall, n_ready;
    n_stall = 0;
    n_ready = 0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (stall) n_stall++;
      if (ready) n_ready++;
    end
    check({name, " idle stall"}, 64'(n_stall), 64'd0);
    check({name, " extra ready"}, 64'(n_ready), 64'd0);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] p;
    reset     = 1'b1;
    start     = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
    operand_a = '0;
    operand_b = '0;
    #2;
    check("reset outputs", 64'({stall, ready, div_zero, hi, lo}), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    vecs.push_back('{"mul 300x200",   1'b0, 1'b0, 16'd300,   16'd200,   16'h0000, 16'hEA60, 1'b0});
    vecs.push_back('{"mul ffffxffff", 1'b0, 1'b0, 16'hFFFF,  16'hFFFF,  16'hFFFE, 16'h0001, 1'b0});
    vecs.push_back('{"div 100/7",     1'b1, 1'b0, 16'd100,   16'd7,     16'd2,    16'd14,   1'b0});
    vecs.push_back('{"div 5/0",       1'b1, 1'b0, 16'd5,     16'd0,     16'h0005, 16'hFFFF, 1'b1});
    vecs.push_back('{"mul 8000x2",    1'b0, 1'b0, 16'h8000,  16'd2,     16'h0001, 16'h0000, 1'b0});
    vecs.push_back('{"div ffff/1",    1'b1, 1'b0, 16'hFFFF,  16'd1,     16'h0000, 16'hFFFF, 1'b0});
    vecs.push_back('{"div 7/100",     1'b1, 1'b0, 16'd7,     16'd100,   16'd7,    16'd0,    1'b0});
    vecs.push_back('{"div ffff/ffff", 1'b1, 1'b0, 16'hFFFF,  16'hFFFF,  16'd0,    16'd1,    1'b0});
`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{"smul -6x7",     1'b0, 1'b1, 16'hFFFA,  16'd7,     16'hFFFF, 16'hFFD6, 1'b0});
    vecs.push_back('{"sdiv -7/2",     1'b1, 1'b1, 16'hFFF9,  16'd2,     16'hFFFF, 16'hFFFD, 1'b0});
`else
    vecs.push_back('{"smul -6x7",     1'b0, 1'b1, 16'hFFFA,  16'd7,     16'h0006, 16'hFFD6, 1'b0});
    vecs.push_back('{"sdiv -7/2",     1'b1, 1'b1, 16'hFFF9,  16'd2,     16'h0001, 16'h7FFC, 1'b0});
`endif
    vecs.push_back('{"sdiv -5/0",     1'b1, 1'b1, 16'hFFFB,  16'd0,     16'hFFFB, 16'hFFFF, 1'b1});

    foreach (vecs[i]) do_op(vecs[i], 0);

    // start pulsed in the middle of RUN, then held in DONE: neither may restart.
    do_op('{"div 100/7 poke run", 1'b1, 1'b0, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0}, 8);
    idle_watch("poke run");
    do_op('{"mul 300x200 poke done", 1'b0, 1'b0, 16'd300, 16'd200, 16'h0000, 16'hEA60, 1'b0}, 17);
    idle_watch("poke done");

    // Asynchronous reset in the middle of RUN clears everything without a clock edge.
    @(posedge clock); #1;
    start = 1'b1; op_div = 1'b0; op_signed = 1'b0; operand_a = 16'd1234; operand_b = 16'd77;
    @(posedge clock); #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async reset stall", 64'(stall), 64'd0);
    check("async reset result", 64'({ready, div_zero, hi, lo}), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
    do_op('{"mul 9x9 after reset", 1'b0, 1'b0, 16'd9, 16'd9, 16'd0, 16'd81, 1'b0}, 0);

    for (int k = 0; k < 8; k++) begin
      v.name      = $sformatf("rand %0d", k);
      v.op_div    = 1'(k & 1);
      v.op_signed = 1'b0;
      v.a         = 16'($urandom);
      v.b         = (k == 5) ? 16'd0 : 16'($urandom_range(1, 65535) >> (k % 4) * 4);
      if (v.op_div) begin
        v.dz = (v.b == 0);
        v.lo = v.dz ? 16'hFFFF : v.a / v.b;
        v.hi = v.dz ? v.a : v.a % v.b;
      end else begin
        p    = 32'(v.a) * 32'(v.b);
        v.hi = p[31:16];
        v.lo = p[15:0];
        v.dz = 1'b0;
      end
      do_op(v, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide sequencer for the 16-bit single-cycle MIPS core. It runs iterative shift-add multiplication and restoring division on operands taken from the register file. While it works, it holds the instruction stream through the stall line the control unit exports as `instr_stall_sl`. On completion it presents the HI/LO result pair and pulses `ready` so the `hi_lo_sl` write path can commit.

## Interface
- `WIDTH`, 16: operand width; HI and LO are each `WIDTH` bits.
- `clock` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request an operation; sampled only in IDLE.
- `op_div` input 1: 0 = multiply, 1 = divide; sampled with `start`.
- `op_signed` input 1: signed operation; honoured only under `MULDIV_SIGNED_EN`.
- `operand_a` input `WIDTH`: multiplicand or dividend; sampled with `start`.
- `operand_b` input `WIDTH`: multiplier or divisor; sampled with `start`.
- `stall` output 1: hold PC and instruction; drives `instr_stall_sl`.
- `ready` output 1: one-cycle pulse, result valid.
- `hi` output `WIDTH`: product upper half, or remainder.
- `lo` output `WIDTH`: product lower half, or quotient.
- `div_zero` output 1: the last divide had a zero divisor; held with the result.

## Operation
- States:
  - IDLE: no operation in progress.
  - RUN: `WIDTH` iterations, with a 5-bit step counter running 0..`WIDTH`-1.
  - DONE: one cycle.
- IDLE with `start`=1:
  - Latch the operands and `op_div`.
  - Clear the accumulator and counter.
  - Go to RUN.
- RUN performs one iteration per cycle:
  - Multiply: if multiplier bit 0 is set, add the multiplicand into the upper accumulator; shift the {acc, multiplier} pair right by 1.
  - Divide: shift {remainder, quotient} left by 1; trial-subtract the divisor; if the result is non-negative, keep it and set quotient bit 0.
  - Counter = `WIDTH`-1 → go to DONE.
- DONE:
  - Load `hi`/`lo` from the accumulator and set `div_zero`.
  - Assert `ready`.
  - Always go to IDLE. `start` in DONE is ignored, so the stalled instruction does not re-trigger.
- Width rules:
  - Multiply accumulation uses a `WIDTH`+1-bit add to keep the carry; the product is exact at 2·`WIDTH` bits.
  - Divide uses a `WIDTH`+1-bit trial subtract.
- Divide by zero: the operation runs the full latency (constant timing). Result is `lo`=all-ones, `hi`=dividend, `div_zero`=1.
- `start` during RUN or DONE is ignored; operand changes during RUN have no effect.
- `hi`, `lo` and `div_zero` hold their value until the next DONE. They do not change in IDLE or RUN.
- Reset, including mid-RUN:
  - State returns to IDLE.
  - `hi`=0, `lo`=0, `div_zero`=0, `ready`=0, counter=0.
  - `stall`=0 immediately (asynchronous).

## Timing
- `stall` is combinational: (IDLE and `start`) or RUN. It rises in the same cycle the instruction presents `start`, so the PC never advances past it.
- For `start` first high in cycle 0:
  - Cycles 0..16 (`WIDTH`+1 cycles): `stall`=1.
  - Cycle 17: DONE, `stall`=0, `ready`=1.
  - Results are visible after the rising edge that ends cycle 16.
- Total latency is `WIDTH`+2 cycles from `start` to the PC advancing.
- Back-to-back: a new `start` is accepted in cycle 18 (IDLE).
- `ready` is registered; it is high for exactly one cycle per operation.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - `op_signed`=1 takes operand magnitudes at start, runs the unsigned core, then applies sign correction in DONE. Latency is unchanged.
  - Product sign is the XOR of the operand signs.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed divide by zero gives `lo`=all-ones, `hi`=dividend.
- `MULDIV_SIGNED_EN` not defined:
  - `op_signed` is ignored and all operations are unsigned.
  - The sign logic is not synthesised.

## Structure
- Shared package `muldiv_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - `MULDIV_DEFAULT_WIDTH`=16;
  - the step-counter width constant.
- Sub-module `muldiv_step`: combinational single iteration (add-shift or subtract-shift), instantiated once.
- FSM, counter and sign handling live in `muldiv_sequencer`.

## Test plan
- Unsigned multiply, 300 × 200:
  - `stall`=1 for 17 cycles.
  - `ready` pulse in cycle 17 with `hi`=0x0000, `lo`=0xEA60.
- Unsigned multiply, 0xFFFF × 0xFFFF → `hi`=0xFFFE, `lo`=0x0001.
- Divide, 100 / 7 → `lo`=14, `hi`=2, `div_zero`=0.
- Divide, 5 / 0 → `lo`=0xFFFF, `hi`=0x0005, `div_zero`=1, after the same 17-cycle stall.
- Reset and ignored start:
  - Assert `reset` in RUN cycle 5 → `stall`, `hi`, `lo` go to 0 at once; a following 9 × 9 returns `lo`=81.
  - `start` pulsed during RUN → no restart and no second `ready`.
- With `MULDIV_SIGNED_EN`:
  - −6 × 7 → `hi`=0xFFFF, `lo`=0xFFD6.
  - −7 / 2 → `lo`=0xFFFD, `hi`=0xFFFF.
  - The same stimulus without the macro, `op_signed`=1, gives the unsigned results.
